// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit (divider4 and its neighbours).
//   DW / VW        : default dividend/quotient and divisor/remainder widths
//   div_state_t    : divider control states
//   DIV_ZERO_QUOT  : quotient reported for a division by zero
package arith_pkg;
    localparam int DW = 16;
    localparam int VW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DW-1:0] DIV_ZERO_QUOT = '1;
endpackage

// File: rtl/divider4_if.sv
// Handshake/operand bundle for the sequential divider.
//   start, ina, inb                   : requester -> divider
//   busy, done, quot, rem, div_zero   : divider -> requester
interface divider4_if #(
    parameter int DW = arith_pkg::DW,
    parameter int VW = arith_pkg::VW
);
    logic          start;
    logic [DW-1:0] ina;
    logic [VW-1:0] inb;
    logic          busy;
    logic          done;
    logic [DW-1:0] quot;
    logic [VW-1:0] rem;
    logic          div_zero;

    modport master (output start, ina, inb,
                    input  busy, done, quot, rem, div_zero);
    modport slave  (input  start, ina, inb,
                    output busy, done, quot, rem, div_zero);
endinterface

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   pr     : current partial remainder (always < divisor, so VW bits suffice)
//   q_msb  : quotient register MSB shifted into the remainder
//   dvs    : divisor
//   pr_nxt : next partial remainder
//   q_bit  : quotient bit shifted into q[0]
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] pr,
    input  logic          q_msb,
    input  logic [VW-1:0] dvs,
    output logic [VW-1:0] pr_nxt,
    output logic          q_bit
);
    logic [VW:0] t;

    assign t     = {pr, q_msb};
    assign q_bit = (t >= {1'b0, dvs});
    // t < 2*dvs, so the difference always fits back into VW bits.
    assign pr_nxt = q_bit ? VW'(t - {1'b0, dvs}) : t[VW-1:0];
endmodule

// File: rtl/divider4.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per clock, start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : divider4_if slave (start/ina/inb in, busy/done/quot/rem/div_zero out)
// Results are registered and only change on entry to DONE.
module divider4 #(
    parameter int DW = arith_pkg::DW,
    parameter int VW = arith_pkg::VW
) (
    input  logic       clk,
    input  logic       rst_n,
    divider4_if.slave  bus
);
    import arith_pkg::*;

    localparam int CW = $clog2(DW);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [VW-1:0] dvs_q,   dvs_d;
    logic [VW-1:0] pr_q,    pr_d;
    logic [DW-1:0] q_q,     q_d;
    logic [DW-1:0] quot_q,  quot_d;
    logic [VW-1:0] rem_q,   rem_d;
    logic          dz_q,    dz_d;

    logic [VW-1:0] pr_nxt;
    logic          q_bit;
    logic          accept;

    div_step #(.VW(VW)) u_step (
        .pr     (pr_q),
        .q_msb  (q_q[DW-1]),
        .dvs    (dvs_q),
        .pr_nxt (pr_nxt),
        .q_bit  (q_bit)
    );

    // DONE accepts too, so back-to-back operations need no idle gap.
    assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        q_d     = q_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    dvs_d = bus.inb;
                    q_d   = bus.ina;
                    pr_d  = '0;
                    cnt_d = '0;
                    if (bus.inb == '0) begin
                        // No iterations: publish the divide-by-zero result now.
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                q_d   = {q_q[DW-2:0], q_bit};
                pr_d  = pr_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW-1)) begin
                    state_d = ST_DONE;
                    quot_d  = {q_q[DW-2:0], q_bit};
                    rem_d   = pr_nxt;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = dz_q;
endmodule
